// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 transmit path: frame states, line levels and defaults.
package rs232_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_MAX_BYTES    = 6;

endpackage

// File: rtl/rs232_byte_transmitter.sv
// Single 8N1 frame serialiser. A load seen in IDLE or in the final stop-bit cycle
// starts the next frame with no gap on the line.
module rs232_byte_transmitter
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx_serial,
  output logic       byte_done,
  output logic       idle
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_t       state_r;
  logic [BAUD_W-1:0] baud_r;
  logic [2:0]        bit_r;
  logic [7:0]        shift_r;
  logic              tx_serial_r;

  // byte_done marks the last cycle of the stop bit so the next frame can be chained
  assign byte_done = (state_r == ST_STOP) && (baud_r == BAUD_LAST);
  assign idle      = (state_r == ST_IDLE);
  assign tx_serial = tx_serial_r;

  // Frame sequencer with baud and bit counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      baud_r      <= '0;
      bit_r       <= 3'd0;
      shift_r     <= 8'h00;
      tx_serial_r <= UART_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          baud_r      <= '0;
          bit_r       <= 3'd0;
          tx_serial_r <= UART_IDLE;
          if (load) begin
            state_r     <= ST_START;
            tx_serial_r <= UART_START;
            shift_r     <= data;
          end
        end
        ST_START: begin
          if (baud_r == BAUD_LAST) begin
            baud_r      <= '0;
            bit_r       <= 3'd0;
            state_r     <= ST_DATA;
            tx_serial_r <= shift_r[0];
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= '0;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              bit_r       <= 3'd0;
              state_r     <= ST_STOP;
              tx_serial_r <= UART_STOP;
            end else begin
              bit_r       <= bit_r + 3'd1;
              tx_serial_r <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_r == BAUD_LAST) begin
            baud_r <= '0;
            if (load) begin
              state_r     <= ST_START;
              tx_serial_r <= UART_START;
              shift_r     <= data;
            end else begin
              state_r     <= ST_IDLE;
              tx_serial_r <= UART_IDLE;
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          tx_serial_r <= UART_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/rs232_response_transmitter.sv
// Sends a latched response buffer as back-to-back 8N1 frames, highest byte first,
// with busy/done/overrun status toward the command processor.
module rs232_response_transmitter
  import rs232_pkg::*;
#(
  parameter int MAX_BYTES    = DEFAULT_MAX_BYTES,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [MAX_BYTES*8-1:0] tx_bytes,
  input  logic [3:0]             tx_num_bytes,
  input  logic                   tx_valid,
  output logic                   tx_serial,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam logic [3:0] MAX_COUNT = 4'(MAX_BYTES);

  logic                   tx_valid_last_r;
  logic [MAX_BYTES*8-1:0] buffer_r;
  logic [3:0]             remaining_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   overrun_pend_r;
  logic                   overrun_r;

  logic       request_s;
  logic       idle_s;
  logic       load_s;
  logic [3:0] num_clamped_s;
  logic       byte_done_s;
  logic       byte_idle_s;

  // remaining_r counts bytes not yet handed to the frame serialiser
  assign request_s     = tx_valid && !tx_valid_last_r;
  assign idle_s        = !busy_r && (remaining_r == 4'd0);
  assign load_s        = (byte_idle_s || byte_done_s) && (remaining_r != 4'd0);
  assign num_clamped_s = (tx_num_bytes > MAX_COUNT) ? MAX_COUNT : tx_num_bytes;

  assign busy    = busy_r;
  assign done    = done_r;
  assign overrun = overrun_r;

  // Request edge detect, buffer/byte sequencing and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_valid_last_r <= 1'b0;
      buffer_r        <= '0;
      remaining_r     <= 4'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      overrun_pend_r  <= 1'b0;
      overrun_r       <= 1'b0;
    end else begin
      tx_valid_last_r <= tx_valid;
      done_r          <= 1'b0;
      overrun_pend_r  <= request_s && !idle_s;
      overrun_r       <= overrun_pend_r;

      if (request_s && idle_s && (num_clamped_s != 4'd0)) begin
        buffer_r    <= tx_bytes;
        remaining_r <= num_clamped_s;
      end else if (load_s) begin
        buffer_r    <= {buffer_r[MAX_BYTES*8-9:0], 8'h00};
        remaining_r <= remaining_r - 4'd1;
      end else begin
        buffer_r    <= buffer_r;
        remaining_r <= remaining_r;
      end

      if (load_s) begin
        busy_r <= 1'b1;
      end else if (busy_r && byte_done_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  rs232_byte_transmitter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clock    (clock),
    .reset    (reset),
    .load     (load_s),
    .data     (buffer_r[MAX_BYTES*8-1 -: 8]),
    .tx_serial(tx_serial),
    .byte_done(byte_done_s),
    .idle     (byte_idle_s)
  );

endmodule
